// File: rtl/popcount_frame_accum.sv
// Per-word popcount summed over a frame (in_last or FRAME_LEN words), result on valid/ready.
// Latency: total visible the cycle after the closing word is accepted.
// Backpressure: while a result waits, in_ready follows out_ready so no word slips in behind a stalled result.

module vector_sum #(
  parameter int W     = 10,
  parameter int OUT_W = $clog2(W+1)
) (
  input  logic [W-1:0]     vec,
  output logic [OUT_W-1:0] sum
);
  always_comb begin
    sum = '0;
    for (int i = 0; i < W; i++) begin
      sum = sum + OUT_W'(vec[i]);
    end
  end
endmodule

module popcount_frame_accum #(
  parameter int DATA_W    = 10,
  parameter int FRAME_LEN = 16,
  parameter int POS_W     = $clog2(DATA_W+1),
  parameter int CNT_W     = $clog2(FRAME_LEN+1),
  parameter int ACC_W     = $clog2(DATA_W*FRAME_LEN+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_valid,
  input  logic              out_ready
);
  typedef enum logic {ACCUM, HOLD} state_t;

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  out_sum_d;
  logic [CNT_W-1:0]  out_count_d;
  logic [POS_W-1:0]  pop;
  logic              accept;
  logic              close;
  logic [ACC_W-1:0]  acc_plus_pop;
  logic [CNT_W-1:0]  cnt_plus_one;

  vector_sum #(.W(DATA_W), .OUT_W(POS_W)) u_vector_sum (
    .vec (in_data),
    .sum (pop)
  );

  assign in_ready     = (state_q == ACCUM) ? 1'b1 : out_ready;
  assign accept       = in_valid && in_ready;
  assign close        = accept && (in_last || (cnt_q == CNT_W'(FRAME_LEN-1)));
  assign acc_plus_pop = acc_q + ACC_W'(pop);
  assign cnt_plus_one = cnt_q + CNT_W'(1);
  assign out_valid    = (state_q == HOLD);

  // acc_q/cnt_q are always zero in HOLD, so a word accepted there starts a fresh frame through the same adders.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_sum_d   = out_sum;
    out_count_d = out_count;
    case (state_q)
      ACCUM: begin
        if (close) begin
          out_sum_d   = acc_plus_pop;
          out_count_d = cnt_plus_one;
          acc_d       = '0;
          cnt_d       = '0;
          state_d     = HOLD;
        end else if (accept) begin
          acc_d = acc_plus_pop;
          cnt_d = cnt_plus_one;
        end
      end
      HOLD: begin
        if (close) begin
          out_sum_d   = acc_plus_pop;
          out_count_d = cnt_plus_one;
          acc_d       = '0;
          cnt_d       = '0;
        end else if (accept) begin
          acc_d   = acc_plus_pop;
          cnt_d   = cnt_plus_one;
          state_d = ACCUM;
        end else if (out_ready) begin
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      out_sum   <= '0;
      out_count <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      out_sum   <= out_sum_d;
      out_count <= out_count_d;
    end
  end
endmodule

// File: tb/tb_popcount_frame_accum.sv
// Directed bench for popcount_frame_accum: expected frame results queued at stimulus, popped by a monitor.
module tb_popcount_frame_accum;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [7:0] out_sum;
  logic [4:0] out_count;
  logic       out_valid;
  logic       out_ready;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] sum;
    logic [4:0] count;
  } exp_t;
  exp_t exp_q[$];

  popcount_frame_accum dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic expect_frame(input int s, input int c);
    exp_t e;
    e.sum   = 8'(s);
    e.count = 5'(c);
    exp_q.push_back(e);
  endtask

  // Present one word from a falling edge and hold it until it is taken on a rising edge.
  task automatic send(input logic [9:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Output monitor: out_ready only changes on falling edges, so the sample holds until the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got sum %0d count %0d, expected no result", out_sum, out_count);
        end else begin
          e = exp_q.pop_front();
          check("result_sum", int'(out_sum), int'(e.sum));
          check("result_count", int'(out_count), int'(e.count));
        end
      end
    end
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_sum", int'(out_sum), 0);
    check("reset_out_count", int'(out_count), 0);
    check("reset_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Frame closed by length: 16 all-ones words.
    expect_frame(160, 16);
    for (int i = 0; i < 16; i++) send(10'h3FF, 1'b0);
    check("len_close_latency", int'(out_valid), 1);
    repeat (2) @(negedge clk);

    // Frame closed by in_last while downstream is stalled.
    out_ready = 1'b0;
    expect_frame(6, 3);
    send(10'h001, 1'b0);
    send(10'h003, 1'b0);
    send(10'h007, 1'b1);

    // Stall with a word offered: result stable, nothing accepted.
    @(negedge clk);
    in_data  = 10'h00F;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #2;
      check("stall_out_valid", int'(out_valid), 1);
      check("stall_out_sum", int'(out_sum), 6);
      check("stall_in_ready", int'(in_ready), 0);
    end

    // Release: the offered word is taken in the same cycle as the result.
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    expect_frame(8, 2);
    send(10'h0F0, 1'b1);

    // Reset mid-frame discards the partial frame.
    for (int i = 0; i < 5; i++) send(10'h3FF, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("midreset_out_valid", int'(out_valid), 0);
    check("midreset_out_sum", int'(out_sum), 0);
    check("midreset_out_count", int'(out_count), 0);
    check("midreset_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    expect_frame(10, 1);
    send(10'h3FF, 1'b1);

    // Gapped valid, zero word still counts.
    expect_frame(5, 2);
    send(10'h000, 1'b0);
    @(negedge clk);
    send(10'h2AA, 1'b1);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("results_outstanding", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
